// File: rtl/alu_divider.sv
// Multi-cycle restoring divider beside the ALU: signed/unsigned quotient and remainder
// with a start/done handshake, one quotient bit per cycle plus a final sign-fix cycle.
module alu_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_r;
    logic             qNeg_r;
    logic             rNeg_r;
    logic             zeroPath_r;
    logic [WIDTH:0]   partRem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] divisorMag_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic             dividendNeg_s;
    logic             divisorNeg_s;

    function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] value, input logic neg);
        logic [WIDTH-1:0] result;
        if (neg) begin
            result = ~value + WIDTH'(1);
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Operand signs and the trial subtraction for the current restoring step.
    always_comb begin
        dividendNeg_s = is_signed & dividend[WIDTH-1];
        divisorNeg_s  = is_signed & divisor[WIDTH-1];
        shifted_s     = {partRem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        trial_s       = shifted_s - {1'b0, divisorMag_r};
    end

    // quo_r shifts the dividend magnitude out at the top while quotient bits enter at the bottom;
    // on the divide-by-zero path it simply parks the raw dividend for the remainder output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            qNeg_r       <= 1'b0;
            rNeg_r       <= 1'b0;
            zeroPath_r   <= 1'b0;
            partRem_r    <= '0;
            quo_r        <= '0;
            divisorMag_r <= '0;
            cnt_r        <= '0;
            quotient     <= '0;
            remainder    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_zero     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy       <= 1'b1;
                        div_zero   <= 1'b0;
                        cnt_r      <= '0;
                        partRem_r  <= '0;
                        qNeg_r     <= dividendNeg_s ^ divisorNeg_s;
                        rNeg_r     <= dividendNeg_s;
                        divisorMag_r <= condNeg(divisor, divisorNeg_s);
                        if (divisor == '0) begin
                            zeroPath_r <= 1'b1;
                            quo_r      <= dividend;
                            state_r    <= FIX;
                        end else begin
                            zeroPath_r <= 1'b0;
                            quo_r      <= condNeg(dividend, dividendNeg_s);
                            state_r    <= RUN;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (!trial_s[WIDTH]) begin
                        partRem_r <= trial_s;
                        quo_r     <= {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        partRem_r <= shifted_s;
                        quo_r     <= {quo_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIX: begin
                    if (zeroPath_r) begin
                        quotient  <= '1;
                        remainder <= quo_r;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= condNeg(quo_r, qNeg_r);
                        remainder <= condNeg(partRem_r[WIDTH-1:0], rNeg_r);
                        div_zero  <= 1'b0;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_divider.sv
// Directed bench for alu_divider: hand-computed quotient/remainder, latency and handshake checks.
module tb_alu_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;

    int errCount;
    int checkCount;

    alu_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .busy(busy), .done(done), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge where done is seen, lat = edges after accept.
    task automatic runOp(input logic sgn, input logic [31:0] a, input logic [31:0] b, output int lat);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'h0BAD_F00D;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(negedge clk);
        checkCount++;
        if ({quotient, remainder, busy, done, div_zero} !== 67'd0) begin
            errCount++;
            $display("FAIL reset_state: q=%h r=%h busy=%b done=%b dz=%b, required all zero", quotient, remainder, busy, done, div_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        int lat;
        runOp(1'b0, 32'd100, 32'd7, lat);
        checkCount++;
        if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2 || div_zero !== 1'b0 || busy !== 1'b0) begin
            errCount++;
            $display("FAIL unsigned_100_7: lat=%0d q=%0d r=%0d dz=%b busy=%b, required lat=33 q=14 r=2 dz=0 busy=0", lat, quotient, remainder, div_zero, busy);
        end
        @(negedge clk);
        checkCount++;
        if (done !== 1'b0 || quotient !== 32'd14) begin
            errCount++;
            $display("FAIL done_pulse: done=%b q=%0d, required done=0 q=14", done, quotient);
        end
    endtask

    task automatic test_signed;
        int lat;
        runOp(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
        checkCount++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            errCount++;
            $display("FAIL signed_m7_2: lat=%0d q=%h r=%h, required lat=33 q=fffffffd r=ffffffff", lat, quotient, remainder);
        end
        runOp(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
        checkCount++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) begin
            errCount++;
            $display("FAIL signed_7_m2: q=%h r=%h, required q=fffffffd r=00000001", quotient, remainder);
        end
        runOp(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat);
        checkCount++;
        if (quotient !== 32'd3 || remainder !== 32'hFFFF_FFFF) begin
            errCount++;
            $display("FAIL signed_m7_m2: q=%h r=%h, required q=00000003 r=ffffffff", quotient, remainder);
        end
    endtask

    task automatic test_div_zero;
        int lat;
        runOp(1'b0, 32'h1234_5678, 32'd0, lat);
        checkCount++;
        if (lat !== 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678 || div_zero !== 1'b1 || busy !== 1'b0) begin
            errCount++;
            $display("FAIL div_zero_unsigned: lat=%0d q=%h r=%h dz=%b busy=%b, required lat=1 q=ffffffff r=12345678 dz=1 busy=0", lat, quotient, remainder, div_zero, busy);
        end
        runOp(1'b0, 32'd8, 32'd2, lat);
        checkCount++;
        if (quotient !== 32'd4 || remainder !== 32'd0 || div_zero !== 1'b0) begin
            errCount++;
            $display("FAIL after_div_zero: q=%0d r=%0d dz=%b, required q=4 r=0 dz=0", quotient, remainder, div_zero);
        end
        runOp(1'b1, 32'hFFFF_FFF9, 32'd0, lat);
        checkCount++;
        if (lat !== 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFF9 || div_zero !== 1'b1) begin
            errCount++;
            $display("FAIL div_zero_signed: lat=%0d q=%h r=%h dz=%b, required lat=1 q=ffffffff r=fffffff9 dz=1", lat, quotient, remainder, div_zero);
        end
    endtask

    task automatic test_extremes;
        int lat;
        runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checkCount++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
            errCount++;
            $display("FAIL signed_overflow: q=%h r=%h, required q=80000000 r=00000000", quotient, remainder);
        end
        runOp(1'b0, 32'hFFFF_FFFF, 32'd1, lat);
        checkCount++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin
            errCount++;
            $display("FAIL unsigned_max_1: q=%h r=%h, required q=ffffffff r=00000000", quotient, remainder);
        end
        runOp(1'b0, 32'd5, 32'd9, lat);
        checkCount++;
        if (quotient !== 32'd0 || remainder !== 32'd5) begin
            errCount++;
            $display("FAIL unsigned_5_9: q=%0d r=%0d, required q=0 r=5", quotient, remainder);
        end
        runOp(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checkCount++;
        if (quotient !== 32'd0 || remainder !== 32'h8000_0000) begin
            errCount++;
            $display("FAIL unsigned_80_ff: q=%h r=%h, required q=00000000 r=80000000", quotient, remainder);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1; is_signed = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(negedge clk);
        start = 1'b0;
        lat = 11;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkCount++;
        if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
            errCount++;
            $display("FAIL ignore_busy_start: lat=%0d q=%0d r=%0d, required lat=33 q=14 r=2", lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        runOp(1'b0, 32'd1000, 32'd3, lat);
        checkCount++;
        if (quotient !== 32'd333 || remainder !== 32'd1) begin
            errCount++;
            $display("FAIL b2b_first: q=%0d r=%0d, required q=333 r=1", quotient, remainder);
        end
        runOp(1'b1, 32'hFFFF_FF9C, 32'd7, lat);
        checkCount++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE) begin
            errCount++;
            $display("FAIL b2b_second: lat=%0d q=%h r=%h, required lat=33 q=fffffff2 r=fffffffe", lat, quotient, remainder);
        end
    endtask

    task automatic test_reset_midop;
        int lat;
        int sawDone;
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkCount++;
        if ({quotient, remainder, busy, done, div_zero} !== 67'd0) begin
            errCount++;
            $display("FAIL async_reset: q=%h r=%h busy=%b done=%b dz=%b, required all zero", quotient, remainder, busy, done, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) sawDone++;
        end
        checkCount++;
        if (sawDone !== 0) begin
            errCount++;
            $display("FAIL no_done_after_reset: active_cycles=%0d, required 0", sawDone);
        end
        runOp(1'b0, 32'd8, 32'd2, lat);
        checkCount++;
        if (lat !== 33 || quotient !== 32'd4 || remainder !== 32'd0) begin
            errCount++;
            $display("FAIL op_after_reset: lat=%0d q=%0d r=%0d, required lat=33 q=4 r=0", lat, quotient, remainder);
        end
    endtask

    initial begin
        errCount = 0;
        checkCount = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_extremes();
        @(negedge clk);
        test_ignore_start();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_divider.md
Name: alu_divider

Overview:
- Multi-cycle iterative divider. It is the inverse-operation companion to the ALU's single-cycle multiplier.
- Computes quotient and remainder for signed (div) and unsigned (divu) 32-bit operands with a start/done handshake.
- Sits beside the ALU in the execute stage. The CPU control unit holds the pipeline while busy=1, then captures the results into HI/LO on done.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- dividend  input  WIDTH  A operand; sampled with start.
- divisor  input  WIDTH  B operand; sampled with start.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle pulse; results are valid from this cycle.
- div_zero  output  1  registered flag; set when the last operation had divisor=0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - quotient=0, remainder=0, busy=0, done=0, div_zero=0.
  - Counter and internal registers cleared.
  - Reset mid-operation aborts it; no done is produced.
- States:
  - IDLE: wait for start.
  - RUN: one restoring-division step per cycle.
  - FIX: sign correction and output register load.
  - IDLE follows FIX.
- IDLE, start=1 at edge k:
  - Latch is_signed.
  - Latch magnitudes: |dividend| and |divisor| when is_signed=1; raw values otherwise.
  - Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend), both only when is_signed=1.
  - busy=1 from edge k. done and div_zero clear at edge k.
- Divide-by-zero fast path (divisor=0 at edge k):
  - No RUN; go straight to FIX.
  - At edge k+1: quotient=all ones (0xFFFFFFFF), remainder=dividend unmodified, div_zero=1, done=1, busy=0.
  - This applies regardless of is_signed.
- Normal path:
  - RUN lasts exactly WIDTH edges (k+1..k+32).
  - Each step: shift the partial remainder left one bit, bringing in the next dividend MSB, then trial-subtract the divisor.
    - Non-negative result: keep it and set quotient bit to 1.
    - Negative result: restore and set quotient bit to 0.
  - The partial remainder is WIDTH+1 bits wide so the trial subtract never loses the borrow.
  - FIX at edge k+33 loads the outputs:
    - quotient = q_neg ? -q : q.
    - remainder = r_neg ? -r : r.
  - done=1 and busy=0 also from edge k+33. Total latency is 33 cycles.
- Signed overflow case, 0x80000000 / 0xFFFFFFFF with is_signed=1:
  - quotient=0x80000000, remainder=0.
  - This falls out of the magnitude math; no special case is needed.
- Sign rules (truncation toward zero):
  - The quotient sign is the XOR of the operand signs.
  - A nonzero remainder takes the sign of the dividend.
  - Invariant: dividend = quotient*divisor + remainder (mod 2^WIDTH).
- done rules:
  - done is high for exactly one cycle.
  - quotient, remainder and div_zero hold their values until the next accepted start.
- start while busy=1: ignored, with no effect on the operation in flight.
- start in the same cycle done is high: accepted, since busy=0 that cycle; the new operation begins at that edge.
- Operand inputs are don't-care except at the accept edge.

Test Plan:
- Unsigned: dividend=100, divisor=7, is_signed=0 → done 33 cycles after the accept edge; quotient=14, remainder=2, div_zero=0.
- Signed: dividend=0xFFFFFFF9 (-7), divisor=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also: dividend=7, divisor=0xFFFFFFFE (-2) → quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: dividend=0x12345678, divisor=0 → done 1 cycle after accept; quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1. A following 8/2 op clears div_zero and gives quotient=4.
- Extremes:
  - Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
  - Unsigned 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0.
  - Unsigned 5 / 9 → quotient=0, remainder=5.
- Handshake:
  - A start pulse with new operands at cycle 10 of a busy op is ignored; the result matches the original operands.
  - A back-to-back start asserted in the done cycle is accepted and completes 33 cycles later.
- Reset: deassert rst_n asynchronously at RUN step 16 → all outputs 0 immediately and state IDLE. No done follows; the next start completes normally.
